if_fetch: RTL and testbench

- Instruction-fetch stage directly downstream of the PC register.
- Takes the current PC, fetches the word from a handshaked instruction memory, and holds the instruction for decode.
- Returns PC4, the sign-extended immediate and the jump index to the PC register, plus a pc_en strobe that advances the PC exactly once per retired fetch.
- Turns the single-cycle PC path into a memory-latency-tolerant fetch loop.

---
 rtl/if_fetch_pkg.sv | 20 ++
 rtl/if_imm_ext.sv | 17 +
 rtl/if_fetch.sv | 158 +++++++++++++++
 tb/tb_if_fetch.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_pkg.sv
// Shared widths, constants and fetch-state encoding for the instruction-fetch stage.
// Imported by if_fetch and if_imm_ext (and usable by decode).
package if_fetch_pkg;

  localparam int PCSIZE      = 32;
  localparam int DATALENGTH  = 32;
  localparam int INSTR_INDEX = 26;

  localparam logic [DATALENGTH-1:0] ZEROWORD  = 32'h0000_0000;
  localparam logic [DATALENGTH-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [2:0] {
    IF_IDLE  = 3'd0,
    IF_REQ   = 3'd1,
    IF_WAIT  = 3'd2,
    IF_HOLD  = 3'd3,
    IF_DRAIN = 3'd4
  } if_state_e;

endpackage

// File: rtl/if_imm_ext.sv
// Combinational immediate / jump-index extraction from an instruction word.
// Kept separate so decode can share the same extraction.
module if_imm_ext
  import if_fetch_pkg::*;
(
  input  logic [DATALENGTH-1:0]  i_instr,
  output logic [DATALENGTH-1:0]  o_sign_imm,
  output logic [INSTR_INDEX-1:0] o_instr_index
);

  logic w_unused_opcode;

  assign o_sign_imm      = {{16{i_instr[15]}}, i_instr[15:0]};
  assign o_instr_index   = i_instr[INSTR_INDEX-1:0];
  assign w_unused_opcode = ^i_instr[DATALENGTH-1:INSTR_INDEX];

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: handshaked imem fetch loop between the PC register and decode.
// Optional build macro FETCH_ALIGN_CHECK_EN: misaligned PC raises fetch_err and parks in IDLE.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter int unsigned           IMEM_TIMEOUT = 255,
  parameter logic [DATALENGTH-1:0] RESET_INSTR  = NOP_INSTR
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PCSIZE-1:0]      pc_in,
  output logic                   pc_en,
  output logic [PCSIZE-1:0]      pc4,
  output logic                   imem_req,
  output logic [PCSIZE-1:0]      imem_addr,
  input  logic                   imem_gnt,
  input  logic                   imem_rvalid,
  input  logic [DATALENGTH-1:0]  imem_rdata,
  input  logic                   id_ready,
  input  logic                   flush,
  output logic [DATALENGTH-1:0]  instr,
  output logic [PCSIZE-1:0]      instr_pc,
  output logic                   instr_valid,
  output logic [DATALENGTH-1:0]  sign_imm,
  output logic [INSTR_INDEX-1:0] instr_index,
  output logic                   fetch_err
);

  localparam int CNT_W = (IMEM_TIMEOUT < 2) ? 1 : $clog2(IMEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(IMEM_TIMEOUT);

  if_state_e             r_state;
  if_state_e             w_next;
  logic [PCSIZE-1:0]     r_imem_addr;
  logic [PCSIZE-1:0]     r_instr_pc;
  logic [DATALENGTH-1:0] r_instr;
  logic                  r_fetch_err;
  logic [CNT_W-1:0]      r_wait_cnt;
  logic [CNT_W-1:0]      w_cnt_inc;
  logic                  w_cnt_live;
  logic                  w_pc_en;
  logic                  w_idle_stall;
  logic                  w_align_hit;
  logic [PCSIZE-1:0]     w_fetch_pc;
  logic [PCSIZE-1:0]     w_next_addr;

  assign pc4 = pc_in + PCSIZE'(4);

`ifdef FETCH_ALIGN_CHECK_EN
  // A misaligned PC locks the stage in IDLE until reset; no request is ever issued.
  logic r_align_lock;

  assign w_align_hit  = (r_state == IF_IDLE) && (pc_in[1:0] != 2'b00);
  assign w_idle_stall = w_align_hit || r_align_lock;
  assign w_fetch_pc   = pc_in;
  assign w_next_addr  = pc4;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_align_lock <= 1'b0;
    end else if (w_align_hit) begin
      r_align_lock <= 1'b1;
    end
  end
`else
  assign w_align_hit  = 1'b0;
  assign w_idle_stall = 1'b0;
  assign w_fetch_pc   = {pc_in[PCSIZE-1:2], 2'b00};
  assign w_next_addr  = {pc4[PCSIZE-1:2], 2'b00};
`endif

  assign w_cnt_inc  = r_wait_cnt + CNT_W'(1);
  assign w_cnt_live = (IMEM_TIMEOUT != 0) && (r_wait_cnt != CNT_MAX);

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    w_next  = r_state;
    w_pc_en = 1'b0;
    case (r_state)
      IF_IDLE: begin
        if (!w_idle_stall) w_next = IF_REQ;
      end
      IF_REQ: begin
        // A grant that coincides with flush still owes us a response, so drain it.
        if (imem_gnt)   w_next = flush ? IF_DRAIN : IF_WAIT;
        else if (flush) w_next = IF_IDLE;
      end
      IF_WAIT: begin
        if (flush)            w_next = imem_rvalid ? IF_IDLE : IF_DRAIN;
        else if (imem_rvalid) w_next = IF_HOLD;
      end
      IF_HOLD: begin
        if (flush) begin
          w_next = IF_IDLE;
        end else if (id_ready) begin
          w_next  = IF_IDLE;
          w_pc_en = 1'b1;
        end
      end
      IF_DRAIN: begin
        if (imem_rvalid) w_next = IF_IDLE;
      end
      default: w_next = IF_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all of them see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IF_IDLE;
      r_imem_addr <= ZEROWORD;
      r_instr     <= RESET_INSTR;
      r_instr_pc  <= ZEROWORD;
      r_fetch_err <= 1'b0;
      r_wait_cnt  <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IF_IDLE: begin
          if (!w_idle_stall) r_imem_addr <= w_fetch_pc;
        end
        IF_REQ: begin
          r_wait_cnt <= '0;
        end
        IF_WAIT: begin
          if (imem_rvalid && !flush) begin
            r_instr    <= imem_rdata;
            r_instr_pc <= r_imem_addr;
          end else if (!imem_rvalid && !flush && w_cnt_live) begin
            r_wait_cnt <= w_cnt_inc;
            if (w_cnt_inc == CNT_MAX) r_fetch_err <= 1'b1;
          end
        end
        IF_HOLD: begin
          // The PC register loads pc4 on this edge, so pc4 is the next fetch address.
          if (w_pc_en) r_imem_addr <= w_next_addr;
        end
        default: ;
      endcase
      if (w_align_hit) r_fetch_err <= 1'b1;
    end
  end

  assign pc_en       = w_pc_en && !rst;
  assign imem_req    = (r_state == IF_REQ);
  assign imem_addr   = r_imem_addr;
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign instr_valid = (r_state == IF_HOLD);
  assign fetch_err   = r_fetch_err;

  if_imm_ext u_imm_ext (
    .i_instr       (r_instr),
    .o_sign_imm    (sign_imm),
    .o_instr_index (instr_index)
  );

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: transaction-level reference model, randomized memory
// timing and flush placement, per-cycle output compare plus literal pins.
`timescale 1ns/1ps
module tb_if_fetch;

  localparam int          TMO       = 4;
  localparam logic [31:0] RST_INSTR = 32'h0000_0000;
  localparam int FL_NONE = 0, FL_REQ = 1, FL_WAIT = 2, FL_HOLD = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in;
  logic        pc_en;
  logic [31:0] pc4;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt, imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_ready, flush;
  logic [31:0] instr, instr_pc, sign_imm;
  logic        instr_valid;
  logic [25:0] instr_index;
  logic        fetch_err;

  always #5 clk = ~clk;

  if_fetch #(.IMEM_TIMEOUT(TMO), .RESET_INSTR(RST_INSTR)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .pc_en(pc_en), .pc4(pc4),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .id_ready(id_ready),
    .flush(flush), .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .sign_imm(sign_imm), .instr_index(instr_index), .fetch_err(fetch_err)
  );

  int n_checks = 0, n_fail = 0, n_pulse = 0, n_consumed = 0;
  logic chk_en = 1'b0;

  // Expected outputs for the current cycle.
  logic        m_req, m_valid, m_pc_en, m_err;
  logic [31:0] m_addr, m_instr, m_ipc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic logic [31:0] addr_of(input logic [31:0] pc);
`ifdef FETCH_ALIGN_CHECK_EN
    return pc;
`else
    return pc & 32'hFFFF_FFFC;
`endif
  endfunction

  always @(negedge clk) begin
    if (pc_en === 1'b1) n_pulse++;
    if (chk_en) begin
      check("imem_req",    32'(imem_req),    32'(m_req));
      check("imem_addr",   imem_addr,        m_addr);
      check("pc_en",       32'(pc_en),       32'(m_pc_en));
      check("instr_valid", 32'(instr_valid), 32'(m_valid));
      check("instr",       instr,            m_instr);
      check("instr_pc",    instr_pc,         m_ipc);
      check("fetch_err",   32'(fetch_err),   32'(m_err));
      check("pc4",         pc4,              pc_in + 32'd4);
      check("sign_imm",    sign_imm,         32'($signed(m_instr[15:0])));
      check("instr_index", 32'(instr_index), m_instr & 32'h03FF_FFFF);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic g, input logic rv, input logic [31:0] rd,
                       input logic idr, input logic fl);
    imem_gnt = g; imem_rvalid = rv; imem_rdata = rd; id_ready = idr; flush = fl;
  endtask

  task automatic model_reset();
    m_req = 1'b0; m_addr = 32'h0; m_pc_en = 1'b0; m_valid = 1'b0;
    m_instr = RST_INSTR; m_ipc = 32'h0; m_err = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      step();
      model_reset();
      chk_en = 1'b1;
    end
    rst = 1'b0;
  endtask

  // One fetch transaction, entered and left with the DUT in its idle cycle.
  task automatic fetch(input int gnt_dly, input int rv_dly, input logic [31:0] data,
                       input int hold_dly, input int fl_mode, input int fl_at,
                       input logic [31:0] redirect);
    drive(1'b0, rb(), $urandom, rb(), 1'b0);
    m_req = 1'b0; m_valid = 1'b0; m_pc_en = 1'b0;
    step();
    m_addr = addr_of(pc_in);
    for (int i = 0; i <= gnt_dly; i++) begin
      m_req = 1'b1;
      if (fl_mode == FL_REQ && i == fl_at) begin
        drive(1'b0, rb(), $urandom, rb(), 1'b1);
        step();
        m_req = 1'b0;
        pc_in = redirect;
        return;
      end
      drive(i == gnt_dly, rb(), $urandom, rb(), 1'b0);
      step();
    end
    m_req = 1'b0;
    for (int j = 0; ; j++) begin
      if (fl_mode == FL_WAIT && j == fl_at) begin
        drive(rb(), j == rv_dly, 32'hDEAD_BEEF, rb(), 1'b1);
        step();
        if (j != rv_dly) begin
          for (int d = 0; d < 2; d++) begin
            drive(rb(), 1'b0, $urandom, rb(), rb());
            step();
          end
          drive(1'b0, 1'b1, 32'hDEAD_BEEF, rb(), 1'b0);
          step();
        end
        pc_in = redirect;
        return;
      end
      drive(rb(), j == rv_dly, (j == rv_dly) ? data : $urandom, rb(), 1'b0);
      step();
      if (j == rv_dly) break;
      if (j + 1 == TMO) m_err = 1'b1;
    end
    m_instr = data; m_ipc = m_addr; m_valid = 1'b1;
    for (int k = 0; ; k++) begin
      if (fl_mode == FL_HOLD && k == fl_at) begin
        drive(rb(), rb(), $urandom, 1'b1, 1'b1);
        m_pc_en = 1'b0;
        step();
        m_valid = 1'b0;
        pc_in = redirect;
        return;
      end
      drive(rb(), rb(), $urandom, k == hold_dly, 1'b0);
      m_pc_en = (k == hold_dly);
      step();
      if (k == hold_dly) begin
        n_consumed++;
        m_pc_en = 1'b0; m_valid = 1'b0;
        pc_in = pc_in + 32'd4;
        m_addr = addr_of(pc_in);
        break;
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded its time bound");
    $fatal(1);
  end

  initial begin
    logic [31:0] redir;
    int gd, rvd, hd, mode, fat;
    pc_in = 32'h0;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    do_reset(2);
    check("reset_req",   32'(imem_req),    32'h0);
    check("reset_addr",  imem_addr,        32'h0);
    check("reset_valid", 32'(instr_valid), 32'h0);
    check("reset_instr", instr,            RST_INSTR);

    // Basic fetch: four-cycle loop at PC 0.
    fetch(0, 0, 32'h2008_0005, 0, FL_NONE, 0, 32'h0);
    check("basic_instr",  instr,     32'h2008_0005);
    check("basic_simm",   sign_imm,  32'h0000_0005);
    check("basic_ipc",    instr_pc,  32'h0);
    check("basic_next",   imem_addr, 32'h4);
    check("basic_pulses", 32'(n_pulse), 32'd1);

    fetch(1, 1, 32'h1000_FFFF, 0, FL_NONE, 0, 32'h0);
    check("neg_simm",  sign_imm,          32'hFFFF_FFFF);
    check("jmp_index", 32'(instr_index),  32'h0000_FFFF);

    // Backpressure: five idle decode cycles in HOLD.
    fetch(0, 1, 32'hAABB_CCDD, 5, FL_NONE, 0, 32'h0);

    // Flush in WAIT at PC 0x40, then redirect to 0x100.
    pc_in = 32'h40;
    fetch(0, 3, 32'h1234_5678, 0, FL_WAIT, 1, 32'h100);
    check("flush_instr", instr,             32'hAABB_CCDD);
    check("flush_valid", 32'(instr_valid),  32'h0);
    fetch(0, 0, 32'h0800_0010, 1, FL_NONE, 0, 32'h0);
    check("redirect_ipc", instr_pc, 32'h100);

    // Flush in REQ and flush+id_ready in HOLD.
    fetch(2, 0, 32'h0, 0, FL_REQ, 1, 32'h200);
    fetch(0, 0, 32'h3C01_8000, 2, FL_HOLD, 1, 32'h300);

    // PC wrap.
    pc_in = 32'hFFFF_FFFC;
    #1;
    check("pc4_wrap", pc4, 32'h0);
    fetch(0, 0, 32'h0000_0020, 0, FL_NONE, 0, 32'h0);
    check("wrap_next", imem_addr, 32'h0);

    // Timeout: six WAIT cycles with TMO=4, sticky afterwards.
    fetch(0, 6, 32'h0BAD_F00D, 0, FL_NONE, 0, 32'h0);
    check("tmo_err", 32'(fetch_err), 32'h1);
    fetch(0, 0, 32'h0000_1234, 0, FL_NONE, 0, 32'h0);

    // Reset in the middle of WAIT; late responses after it must be ignored.
    drive(1'b0, 1'b0, 32'h0, rb(), 1'b0);
    m_req = 1'b0; m_valid = 1'b0; m_pc_en = 1'b0;
    step();
    m_addr = addr_of(pc_in);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    m_req = 1'b1;
    step();
    m_req = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    step();
    do_reset(1);
    check("rst_clears_err", 32'(fetch_err), 32'h0);
    fetch(0, 1, 32'h2409_FFFE, 0, FL_NONE, 0, 32'h0);

    for (int it = 0; it < 40; it++) begin
      gd = $urandom_range(2, 0);
      rvd = $urandom_range(3, 0);
      hd = $urandom_range(3, 0);
      mode = $urandom_range(5, 0);
      redir = $urandom;
`ifdef FETCH_ALIGN_CHECK_EN
      redir = redir & 32'hFFFF_FFFC;
`endif
      case (mode)
        3: begin fat = $urandom_range(gd, 0);  fetch(gd, rvd, $urandom, hd, FL_REQ,  fat, redir); end
        4: begin fat = $urandom_range(rvd, 0); fetch(gd, rvd, $urandom, hd, FL_WAIT, fat, redir); end
        5: begin fat = $urandom_range(hd, 0);  fetch(gd, rvd, $urandom, hd, FL_HOLD, fat, redir); end
        default: fetch(gd, rvd, $urandom, hd, FL_NONE, 0, redir);
      endcase
    end

`ifdef FETCH_ALIGN_CHECK_EN
    pc_in = 32'h2;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    m_req = 1'b0; m_valid = 1'b0; m_pc_en = 1'b0;
    step();
    m_err = 1'b1;
    pc_in = 32'h8;
    for (int i = 0; i < 4; i++) step();
    check("align_err", 32'(fetch_err), 32'h1);
`else
    pc_in = 32'h0000_0046;
    fetch(0, 0, 32'h0000_0001, 0, FL_NONE, 0, 32'h0);
    check("unaligned_ipc", instr_pc, 32'h0000_0044);
`endif

    check("pc_en_pulses", 32'(n_pulse), 32'(n_consumed));
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
